// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM protocol types: the 32-bit data word and the RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_responder_pkg.sv
// Address-checking helpers and op encoding for the RAM responder.
package ram_responder_pkg;

    import cpu_types_pkg::*;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    function automatic logic addr_aligned(input word_t a);
        return (a[1:0] == 2'b00);
    endfunction

    // Word index is the byte address with the two byte-select bits dropped.
    function automatic logic addr_in_range(input word_t a, input int unsigned words);
        return ({2'b00, a[31:2]} < words);
    endfunction

endpackage

// File: rtl/ram_responder_if.sv
// cpu_ram_if bundle between memory_control (master) and the RAM responder (slave).
interface ram_responder_if;

    import cpu_types_pkg::*;

    word_t     memaddr;
    word_t     memstore;
    logic      memREN;
    logic      memWEN;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output memaddr,
        output memstore,
        output memREN,
        output memWEN,
        input  ramload,
        input  ramstate
    );

    modport slave (
        input  memaddr,
        input  memstore,
        input  memREN,
        input  memWEN,
        output ramload,
        output ramstate
    );

endinterface

// File: rtl/ram_responder_ram_array.sv
// WORDS x 32 storage: one synchronous write port, one combinational read port,
// whole array cleared asynchronously on rst.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  word_t            wdata,
    input  logic [IDX_W-1:0] raddr,
    output word_t            rdata
);

    word_t mem_reg [WORDS];

    // Per-word registers so the async clear applies to every entry at once.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (we && (waddr == IDX_W'(gi))) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for cpu_ram_if: fixed-latency RAM model returning
// FREE/BUSY/ACCESS/ERROR with read data on ACCESS.
module ram_responder
    import cpu_types_pkg::*;
    import ram_responder_pkg::*;
#(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned LAT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    ram_responder_if.slave  bus
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic {IDLE, WAIT} fsm_t;

    fsm_t             state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    word_t            addr_reg,  addr_next;
    logic             op_reg,    op_next;
    word_t            data_reg,  data_next;

    logic      req_any, req_err, req_valid, req_match;
    logic      mem_we;
    word_t     mem_rdata;
    ramstate_t ramstate_c;
    word_t     ramload_c;

    assign req_any   = bus.memREN | bus.memWEN;
    assign req_err   = (bus.memREN & bus.memWEN) |
                       (req_any & (~addr_aligned(bus.memaddr) |
                                   ~addr_in_range(bus.memaddr, WORDS)));
    assign req_valid = req_any & ~req_err;
    // Write data only matters for writes; a read is steady on address alone.
    assign req_match = req_valid &&
                       (bus.memaddr == addr_reg) &&
                       (bus.memWEN == op_reg) &&
                       (!bus.memWEN || (bus.memstore == data_reg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            op_reg    <= OP_READ;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            op_reg    <= op_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        op_next    = op_reg;
        data_next  = data_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = WAIT;
                    cnt_next   = CNT_LOAD;
                    addr_next  = bus.memaddr;
                    op_next    = bus.memWEN ? OP_WRITE : OP_READ;
                    data_next  = bus.memstore;
                end
            end
            WAIT: begin
                if (req_err) begin
                    state_next = IDLE;
                end else if (req_match) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else if (req_valid) begin
                    // Changed request: drop the old one and start counting afresh.
                    cnt_next  = CNT_LOAD;
                    addr_next = bus.memaddr;
                    op_next   = bus.memWEN ? OP_WRITE : OP_READ;
                    data_next = bus.memstore;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset also forces the combinational outputs so a held request reads FREE.
    always_comb begin
        ramstate_c = FREE;
        ramload_c  = '0;
        mem_we     = 1'b0;
        if (rst) begin
            ramstate_c = FREE;
        end else if (req_err) begin
            ramstate_c = ERROR;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (req_valid) ramstate_c = BUSY;
                end
                WAIT: begin
                    if (req_match) begin
                        if (cnt_reg != '0) begin
                            ramstate_c = BUSY;
                        end else begin
                            ramstate_c = ACCESS;
                            if (op_reg == OP_WRITE) mem_we    = 1'b1;
                            else                    ramload_c = mem_rdata;
                        end
                    end else if (req_valid) begin
                        ramstate_c = BUSY;
                    end
                end
                default: ramstate_c = FREE;
            endcase
        end
    end

    assign bus.ramstate = ramstate_c;
    assign bus.ramload  = ramload_c;

    ram_array #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_ram_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (addr_reg[IDX_W+1:2]),
        .wdata (data_reg),
        .raddr (addr_reg[IDX_W+1:2]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench: directed steps push expected ramstate/ramload, a negedge
// monitor pops and compares. Covers a LAT=2 and a LAT=1 instance.
module tb_ram_responder;

    import cpu_types_pkg::*;

    typedef struct packed {
        logic [15:0] id;
        logic [1:0]  st;
        logic [31:0] ld;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_responder_if bus2 ();
    ram_responder_if bus1 ();

    ram_responder #(.WORDS(1024), .LAT(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    ram_responder #(.WORDS(1024), .LAT(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    exp_t q2[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_id = 0;
    logic done    = 1'b0;
    exp_t e_mon;

    // One cycle of stimulus on the chosen instance plus its expected output.
    task automatic drive(input bit inst, input logic ren, input logic wen,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic r, input ramstate_t est, input logic [31:0] eld);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        step_id++;
        e.id = 16'(step_id);
        e.st = est;
        e.ld = eld;
        if (!inst) begin
            bus2.memREN = ren; bus2.memWEN = wen;
            bus2.memaddr = addr; bus2.memstore = data;
            q2.push_back(e);
        end else begin
            bus1.memREN = ren; bus1.memWEN = wen;
            bus1.memaddr = addr; bus1.memstore = data;
            q1.push_back(e);
        end
    endtask

    task automatic idle(input bit inst);
        drive(inst, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, FREE, 32'h0);
    endtask

    // Steady read on LAT=2: two BUSY then ACCESS with the given data.
    task automatic read2(input logic [31:0] addr, input logic [31:0] eld);
        drive(1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b0, BUSY, 32'h0);
        drive(1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b0, BUSY, 32'h0);
        drive(1'b0, 1'b1, 1'b0, addr, 32'h0, 1'b0, ACCESS, eld);
    endtask

    task automatic write2(input logic [31:0] addr, input logic [31:0] data);
        drive(1'b0, 1'b0, 1'b1, addr, data, 1'b0, BUSY, 32'h0);
        drive(1'b0, 1'b0, 1'b1, addr, data, 1'b0, BUSY, 32'h0);
        drive(1'b0, 1'b0, 1'b1, addr, data, 1'b0, ACCESS, 32'h0);
    endtask

    always @(negedge clk) begin
        if (q2.size() != 0) begin
            e_mon = q2.pop_front();
            n_tests++;
            if (bus2.ramstate !== e_mon.st || bus2.ramload !== e_mon.ld) begin
                n_fail++;
                $display("FAIL lat2 step %0d: got ramstate=%0d ramload=%h, required ramstate=%0d ramload=%h",
                         e_mon.id, bus2.ramstate, bus2.ramload, e_mon.st, e_mon.ld);
            end else begin
                $display("[TB] lat2 step %0d ok ramstate=%0d ramload=%h",
                         e_mon.id, bus2.ramstate, bus2.ramload);
            end
        end
        if (q1.size() != 0) begin
            e_mon = q1.pop_front();
            n_tests++;
            if (bus1.ramstate !== e_mon.st || bus1.ramload !== e_mon.ld) begin
                n_fail++;
                $display("FAIL lat1 step %0d: got ramstate=%0d ramload=%h, required ramstate=%0d ramload=%h",
                         e_mon.id, bus1.ramstate, bus1.ramload, e_mon.st, e_mon.ld);
            end else begin
                $display("[TB] lat1 step %0d ok ramstate=%0d ramload=%h",
                         e_mon.id, bus1.ramstate, bus1.ramload);
            end
        end
        if (done) begin
            n_tests++;
            if (q1.size() + q2.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d expectations left, required 0", q1.size() + q2.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus2.memREN = 1'b0; bus2.memWEN = 1'b0; bus2.memaddr = '0; bus2.memstore = '0;
        bus1.memREN = 1'b0; bus1.memWEN = 1'b0; bus1.memaddr = '0; bus1.memstore = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Reset state, then first read of cleared memory
        idle(1'b0);
        read2(32'h10, 32'h0);
        idle(1'b0);

        // Write then read-back same address
        write2(32'h10, 32'hDEADBEEF);
        idle(1'b0);
        read2(32'h10, 32'hDEADBEEF);
        idle(1'b0);

        // Error cases: misaligned, both strobes, out of range (read and write)
        drive(1'b0, 1'b1, 1'b0, 32'h13,   32'h0,        1'b0, ERROR, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h10,   32'h12345678, 1'b0, ERROR, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h1000, 32'h55,       1'b0, ERROR, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,        1'b0, ERROR, 32'h0);
        idle(1'b0);
        read2(32'h10, 32'hDEADBEEF);
        read2(32'h0, 32'h0);

        // Error while waiting aborts the write
        drive(1'b0, 1'b0, 1'b1, 32'h14, 32'h9, 1'b0, BUSY,  32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h14, 32'h9, 1'b0, ERROR, 32'h0);
        idle(1'b0);
        read2(32'h14, 32'h0);

        // Address changes after one BUSY: restart, only 0x24 is written
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1, 1'b0, BUSY,   32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h24, 32'h1, 1'b0, BUSY,   32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h24, 32'h1, 1'b0, BUSY,   32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h24, 32'h1, 1'b0, ACCESS, 32'h0);
        idle(1'b0);
        read2(32'h20, 32'h0);
        read2(32'h24, 32'h1);
        idle(1'b0);

        // Request dropped mid-wait: no write
        drive(1'b0, 1'b0, 1'b1, 32'h28, 32'h7, 1'b0, BUSY, 32'h0);
        idle(1'b0);
        read2(32'h28, 32'h0);

        // Request held past ACCESS is serviced again
        read2(32'h24, 32'h1);
        read2(32'h24, 32'h1);
        idle(1'b0);

        // Reset mid-wait: immediate FREE, nothing committed, array cleared
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h5, 1'b0, BUSY, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h5, 1'b1, FREE, 32'h0);
        idle(1'b0);
        read2(32'h30, 32'h0);
        read2(32'h10, 32'h0);
        idle(1'b0);

        // LAT=1 instance: write two words, then back-to-back reads
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, BUSY,   32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0, ACCESS, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 1'b0, BUSY,   32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h4, 32'h0BADF00D, 1'b0, ACCESS, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, BUSY,   32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, ACCESS, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0, BUSY,   32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0,        1'b0, ACCESS, 32'h0BADF00D);
        idle(1'b1);

        repeat (2) @(posedge clk);
        done = 1'b1;
    end

endmodule
